// File: rtl/triad_stream_arbiter.sv
// Per-channel triad FIFOs drained round-robin onto one valid/ready stream; also owns sys_ts.
// Optional build macro TRIAD_TS_STAMP_EN: store sys_ts with each word and present it on out_ts.
`timescale 1ns/1ps
module triad_stream_arbiter #(
  parameter int N_TRIADS = 3,
  parameter int TRIAD_W  = 68,
  parameter int DEPTH    = 4,
  parameter int TS_W     = 24,
  localparam int CW      = (N_TRIADS > 1) ? $clog2(N_TRIADS) : 1
) (
  input  logic                        clk_96MHz,
  input  logic                        rst_n,
  output logic [TS_W-1:0]             sys_ts,
  input  logic [N_TRIADS-1:0]         in_avl,
  input  logic [N_TRIADS*TRIAD_W-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [TRIAD_W-1:0]          out_data,
  output logic [CW-1:0]               out_chan,
  output logic [TS_W-1:0]             out_ts,
  output logic [N_TRIADS-1:0]         ovf,
  input  logic                        clr_ovf
);

  localparam int AW = $clog2(DEPTH);

  // Stream handshake: a word transfers on any edge where out_valid=1 and out_ready=1;
  // while out_valid=1 and out_ready=0 the offered word is held unchanged.

  logic [TS_W-1:0]     ts_q;
  logic [AW:0]         wr_ptr [N_TRIADS];
  logic [AW:0]         rd_ptr [N_TRIADS];
  logic [TRIAD_W-1:0]  mem    [N_TRIADS][DEPTH];
  logic [N_TRIADS-1:0] empty, full, push_ok, drop, pop;
  logic                load, grant_vld;
  logic [CW-1:0]       grant, idx, rr_ptr;
  logic [TRIAD_W-1:0]  head_data;
  logic                out_valid_q;
  logic [TRIAD_W-1:0]  out_data_q;
  logic [CW-1:0]       out_chan_q;
  logic [N_TRIADS-1:0] ovf_q;

  always_ff @(posedge clk_96MHz or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_q + 1'b1;
  end

  assign sys_ts = ts_q;

  always_comb begin
    for (int k = 0; k < N_TRIADS; k++) begin
      empty[k] = (wr_ptr[k] == rd_ptr[k]);
      full[k]  = (wr_ptr[k][AW] != rd_ptr[k][AW]) &&
                 (wr_ptr[k][AW-1:0] == rd_ptr[k][AW-1:0]);
    end
  end

  // Search starts one past the last grant so every channel gets a turn.
  always_comb begin
    load      = !out_valid_q || out_ready;
    grant_vld = 1'b0;
    grant     = '0;
    idx       = rr_ptr;
    for (int i = 0; i < N_TRIADS; i++) begin
      idx = (idx == CW'(N_TRIADS - 1)) ? '0 : idx + 1'b1;
      if (!grant_vld && !empty[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N_TRIADS; k++) begin
      pop[k]     = load && grant_vld && (grant == CW'(k));
      push_ok[k] = in_avl[k] && (!full[k] || pop[k]);
      drop[k]    = in_avl[k] && full[k] && !pop[k];
    end
  end

  assign head_data = mem[grant][rd_ptr[grant][AW-1:0]];

  always_ff @(posedge clk_96MHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_TRIADS; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_TRIADS; k++) begin
        if (push_ok[k]) wr_ptr[k] <= wr_ptr[k] + 1'b1;
        if (pop[k])     rd_ptr[k] <= rd_ptr[k] + 1'b1;
      end
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk_96MHz) begin
    for (int k = 0; k < N_TRIADS; k++) begin
      if (push_ok[k]) mem[k][wr_ptr[k][AW-1:0]] <= in_data[k*TRIAD_W +: TRIAD_W];
    end
  end

  always_ff @(posedge clk_96MHz or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      rr_ptr      <= '0;
    end else if (load) begin
      out_valid_q <= grant_vld;
      if (grant_vld) begin
        out_data_q <= head_data;
        out_chan_q <= grant;
        rr_ptr     <= grant;
      end
    end
  end

  // A fresh overflow beats a simultaneous clear.
  always_ff @(posedge clk_96MHz or negedge rst_n) begin
    if (!rst_n) ovf_q <= '0;
    else        ovf_q <= (clr_ovf ? '0 : ovf_q) | drop;
  end

`ifdef TRIAD_TS_STAMP_EN
  logic [TS_W-1:0] ts_mem [N_TRIADS][DEPTH];
  logic [TS_W-1:0] out_ts_q;

  always_ff @(posedge clk_96MHz) begin
    for (int k = 0; k < N_TRIADS; k++) begin
      if (push_ok[k]) ts_mem[k][wr_ptr[k][AW-1:0]] <= ts_q;
    end
  end

  always_ff @(posedge clk_96MHz or negedge rst_n) begin
    if (!rst_n)                out_ts_q <= '0;
    else if (load && grant_vld) out_ts_q <= ts_mem[grant][rd_ptr[grant][AW-1:0]];
  end

  assign out_ts = out_ts_q;
`else
  assign out_ts = '0;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_triad_stream_arbiter.sv
// Directed and randomized bench for triad_stream_arbiter against a queue-based reference model.
`timescale 1ns/1ps
module tb_triad_stream_arbiter;

  localparam int N  = 3;
  localparam int W  = 68;
  localparam int D  = 4;
  localparam int TW = 24;
  localparam int CW = 2;

  // clock / reset
  logic clk_96MHz = 1'b0;
  always #5 clk_96MHz = ~clk_96MHz;

  logic           rst_n;
  logic [N-1:0]   in_avl;
  logic [N*W-1:0] in_data;
  logic           out_ready, clr_ovf;
  logic [TW-1:0]  sys_ts, out_ts;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [CW-1:0]  out_chan;
  logic [N-1:0]   ovf;

  logic [3:0]     s_sys_ts, s_out_ts;
  logic           s_out_valid;
  logic [W-1:0]   s_out_data;
  logic [CW-1:0]  s_out_chan;
  logic [N-1:0]   s_ovf;

  triad_stream_arbiter #(.N_TRIADS(N), .TRIAD_W(W), .DEPTH(D), .TS_W(TW)) dut (
    .clk_96MHz(clk_96MHz), .rst_n(rst_n), .sys_ts(sys_ts), .in_avl(in_avl),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_chan(out_chan), .out_ts(out_ts), .ovf(ovf),
    .clr_ovf(clr_ovf));

  // Narrow-timestamp copy so the counter wrap is reachable in a short run.
  triad_stream_arbiter #(.N_TRIADS(N), .TRIAD_W(W), .DEPTH(D), .TS_W(4)) dut_s (
    .clk_96MHz(clk_96MHz), .rst_n(rst_n), .sys_ts(s_sys_ts), .in_avl(in_avl),
    .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_chan(s_out_chan), .out_ts(s_out_ts), .ovf(s_ovf),
    .clr_ovf(clr_ovf));

  // reference model state
  logic [W-1:0]  exp_q [N][$];
  logic [TW-1:0] stamp_q [N][$];
  logic          m_valid;
  logic [W-1:0]  m_data;
  int            m_chan;
  logic [TW-1:0] m_ts;
  logic [N-1:0]  m_ovf;
  int            m_rr;
  logic [TW-1:0] m_sys;
  logic [3:0]    m_sys_s;

  int total = 0;
  int bad   = 0;

  // scoreboard compare
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      exp_q[k].delete();
      stamp_q[k].delete();
    end
    m_valid = 1'b0; m_data = '0; m_chan = 0; m_ts = '0;
    m_ovf = '0; m_rr = 0; m_sys = '0; m_sys_s = '0;
  endtask

  function automatic logic [TW-1:0] exp_out_ts();
`ifdef TRIAD_TS_STAMP_EN
    return m_ts;
`else
    return '0;
`endif
  endfunction

  // driver: advance model over one edge with the currently driven inputs, then compare
  task automatic tick();
    int           g;
    logic [W-1:0] nd;
    logic [TW-1:0] nts;
    logic [N-1:0] drops;
    logic         ld;
    ld = !m_valid || out_ready;
    g = -1;
    nd = '0;
    nts = '0;
    if (ld) begin
      for (int i = 1; i <= N; i++) begin
        int k;
        k = (m_rr + i) % N;
        if (g < 0 && exp_q[k].size() > 0) g = k;
      end
    end
    if (g >= 0) begin
      nd  = exp_q[g].pop_front();
      nts = stamp_q[g].pop_front();
    end
    drops = '0;
    for (int k = 0; k < N; k++) begin
      if (in_avl[k]) begin
        if (exp_q[k].size() < D) begin
          exp_q[k].push_back(in_data[k*W +: W]);
          stamp_q[k].push_back(m_sys);
        end else begin
          drops[k] = 1'b1;
        end
      end
    end
    m_ovf = (clr_ovf ? '0 : m_ovf) | drops;
    if (ld) begin
      if (g >= 0) begin
        m_valid = 1'b1; m_data = nd; m_chan = g; m_ts = nts; m_rr = g;
      end else begin
        m_valid = 1'b0;
      end
    end
    m_sys   = m_sys + 1'b1;
    m_sys_s = m_sys_s + 1'b1;
    @(posedge clk_96MHz);
    #1;
    chk("sys_ts", sys_ts, m_sys);
    chk("sys_ts_narrow", s_sys_ts, m_sys_s);
    chk("out_valid", out_valid, m_valid);
    chk("ovf", ovf, m_ovf);
    if (m_valid) begin
      chk("out_data", out_data, m_data);
      chk("out_chan", out_chan, m_chan);
      chk("out_ts", out_ts, exp_out_ts());
    end
  endtask

  task automatic idle_inputs();
    in_avl = '0; clr_ovf = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk_96MHz);
    idle_inputs();
    model_reset();
    @(negedge clk_96MHz);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int n);
    in_avl = '0; out_ready = 1'b1;
    repeat (n) tick();
  endtask

  task automatic push_one(input int ch, input logic [W-1:0] word);
    in_avl = '0;
    in_avl[ch] = 1'b1;
    in_data[ch*W +: W] = word;
  endtask

  initial begin
    rst_n = 1'b0; in_avl = '0; in_data = '0; out_ready = 1'b1; clr_ovf = 1'b0;
    model_reset();

    // reset: inputs toggled while held in reset, outputs must stay zero
    for (int i = 0; i < 4; i++) begin
      in_avl  = N'($urandom_range(0, 7));
      in_data = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      @(posedge clk_96MHz);
      #1;
      chk("rst_sys_ts", sys_ts, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_chan", out_chan, 0);
      chk("rst_out_ts", out_ts, 0);
      chk("rst_ovf", ovf, 0);
    end
    apply_reset();
    out_ready = 1'b1;
    repeat (3) tick();

    // round robin from rr_ptr=0: expect ch1, ch2, ch0
    in_data[0*W +: W] = 68'hA0;
    in_data[1*W +: W] = 68'hB1;
    in_data[2*W +: W] = 68'hC2;
    in_avl = 3'b111;
    tick();
    in_avl = '0;
    tick(); chk("rr_first_chan", out_chan, 1);  chk("rr_first_data", out_data, 68'hB1);
    tick(); chk("rr_second_chan", out_chan, 2); chk("rr_second_data", out_data, 68'hC2);
    tick(); chk("rr_third_chan", out_chan, 0);  chk("rr_third_data", out_data, 68'hA0);
    tick(); chk("rr_idle_valid", out_valid, 0);

    // single word latency
    push_one(1, 68'hABC);
    tick(); chk("single_t_valid", out_valid, 0);
    in_avl = '0;
    tick();
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 68'hABC);
    chk("single_chan", out_chan, 1);
    tick(); chk("single_after_valid", out_valid, 0);

    // backpressure and overflow on ch0
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push_one(0, 68'h100 + 68'(i));
      tick();
    end
    in_avl = '0;
    repeat (2) tick();
    chk("ovf0_set", ovf[0], 1);
    chk("frozen_data", out_data, 68'h100);
    drain(7);
    chk("drained_valid", out_valid, 0);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("ovf_cleared", ovf, 0);

    // full FIFO popped and pushed in the same cycle
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_one(0, 68'h200 + 68'(i));
      tick();
    end
    out_ready = 1'b1;
    push_one(0, 68'h205);
    tick();
    chk("fullpop_no_ovf", ovf, 0);
    drain(6);
    chk("fullpop_ovf_end", ovf, 0);

    // timestamp capture: push at sys_ts=100, hold the word 10 cycles
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 200 && m_sys != 24'd100; i++) tick();
    chk("ts_reached_100", sys_ts, 100);
    push_one(2, 68'h5A5);
    tick();
    in_avl = '0;
    repeat (10) tick();
`ifdef TRIAD_TS_STAMP_EN
    chk("stamp_out_ts", out_ts, 100);
`else
    chk("stamp_out_ts", out_ts, 0);
`endif
    drain(3);

    // randomized traffic with bursts of backpressure
    for (int i = 0; i < 400; i++) begin
      in_avl = N'($urandom_range(0, 7));
      for (int k = 0; k < N; k++)
        in_data[k*W +: W] = {4'($urandom_range(0, 15)), $urandom(), $urandom()};
      out_ready = ((i / 40) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      clr_ovf = ($urandom_range(0, 15) == 0);
      tick();
    end
    clr_ovf = 1'b0;
    drain(20);
    chk("final_idle", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
